// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin arbiter sharing one 32-bit carry-increment adder among NREQ requesters
// Optional per-requester sticky overflow flags are built when ADDARB_STICKY_OF_EN is defined.

module carry_increment_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [4:0] carry;

    assign carry[0] = cin_i;

    // Each 8-bit block precomputes +0 and +1 results; the ripple carry only selects.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [8:0] s0;
        logic [8:0] s1;
        assign s0 = {1'b0, a_i[8*g +: 8]} + {1'b0, b_i[8*g +: 8]};
        assign s1 = s0 + 9'd1;
        assign sum_o[8*g +: 8] = carry[g] ? s1[7:0] : s0[7:0];
        assign carry[g+1]      = carry[g] ? s1[8]   : s0[8];
    end

    assign cout_o = carry[4];
endmodule

module adder_share_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_sum,
    output logic                 rsp_cout,
`ifdef ADDARB_STICKY_OF_EN
    input  logic [NREQ-1:0]      of_clr,
    output logic [NREQ-1:0]      of_sticky,
`endif
    output logic                 rsp_of
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [31:0]     op_a_q;
    logic [31:0]     op_b_q;
    logic            op_cin_q;
    logic [IDW-1:0]  op_id_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [31:0]     rsp_sum_q;
    logic            rsp_cout_q;
    logic            rsp_of_q;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic            accept;
    logic [31:0]     add_sum;
    logic            add_cout;
    logic            add_of;

    // Scan starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            logic [IDW-1:0] cand;
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept    = grant_found &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));
    assign req_ready = (accept && !rst) ? (NREQ'(1) << grant_idx) : '0;

    carry_increment_adder u_add (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .cin_i  (op_cin_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign add_of = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_of_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_a_q   <= req_a[int'(grant_idx)*32 +: 32];
                op_b_q   <= req_b[int'(grant_idx)*32 +: 32];
                op_cin_q <= req_cin[grant_idx];
                op_id_q  <= grant_idx;
                ptr_q    <= grant_idx;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) state_q <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_id_q    <= op_id_q;
                    rsp_sum_q   <= add_sum;
                    rsp_cout_q  <= add_cout;
                    rsp_of_q    <= add_of;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= accept ? S_EXEC : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_of    = rsp_of_q;

`ifdef ADDARB_STICKY_OF_EN
    logic [NREQ-1:0] of_sticky_q;
    logic [NREQ-1:0] of_set;

    assign of_set = ((state_q == S_EXEC) && add_of) ? (NREQ'(1) << op_id_q) : '0;

    // Set is OR-ed in after the clear so a coincident overflow keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            of_sticky_q <= '0;
        end else begin
            of_sticky_q <= (of_sticky_q & ~of_clr) | of_set;
        end
    end

    assign of_sticky = of_sticky_q;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - scoreboard bench for adder_share_arbiter with a round-robin reference model

module tb_adder_share_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     req_cin;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_sum;
    logic                rsp_cout;
    logic                rsp_of;
`ifdef ADDARB_STICKY_OF_EN
    logic [NREQ-1:0]     of_clr = '0;
    logic [NREQ-1:0]     of_sticky;
`endif

    adder_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADDARB_STICKY_OF_EN
        .of_clr    (of_clr),
        .of_sticky (of_sticky),
`endif
        .rsp_of    (rsp_of)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    sum;
        logic           cout;
        logic           of;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one op in flight, visible two cycles after accept,
    // winner is the first requester after the previous winner in circular order.
    int              ptr_m = NREQ - 1;
    int              age   = 0;
    int              pick;
    int              cyc   = 0;
    bit              outst = 0;
    bit              resp_vis;
    bit              can_acc;
    logic [NREQ-1:0] exp_rdy;
    logic [32:0]     full;
    logic [31:0]     ma, mb;
    exp_t            ne;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            outst = 0;
            age   = 0;
            ptr_m = NREQ - 1;
        end else begin
            if (outst) age++;
            resp_vis = outst && (age >= 2);
            can_acc  = !outst || (resp_vis && rsp_ready);
            pick = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (ptr_m + k) % NREQ;
                if (pick < 0 && req_valid[idx]) pick = idx;
            end
            exp_rdy = (can_acc && pick >= 0) ? (NREQ'(1) << pick) : '0;
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rsp_valid", 64'(rsp_valid), 64'(resp_vis));
            if (resp_vis && rsp_ready) outst = 0;
            if (exp_rdy != '0) begin
                ma      = req_a[32*pick +: 32];
                mb      = req_b[32*pick +: 32];
                full    = {1'b0, ma} + {1'b0, mb} + 33'(req_cin[pick]);
                ne.id   = IDW'(pick);
                ne.sum  = full[31:0];
                ne.cout = full[32];
                ne.of   = (ma[31] == mb[31]) && (full[31] != ma[31]);
                q.push_back(ne);
                ptr_m = pick;
                outst = 1;
                age   = 0;
            end
        end
    end

    exp_t me;
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id %0d sum %0h expected no response", rsp_id, rsp_sum);
            end else begin
                me = q.pop_front();
                chk("rsp_id",   64'(rsp_id),   64'(me.id));
                chk("rsp_sum",  64'(rsp_sum),  64'(me.sum));
                chk("rsp_cout", 64'(rsp_cout), 64'(me.cout));
                chk("rsp_of",   64'(rsp_of),   64'(me.of));
            end
        end
    end

    logic [NREQ-1:0] last_acc;
    int              stepcnt = 0;

    task automatic step();
        logic [NREQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
        last_acc  = acc;
        stepcnt++;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i]        = c;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_acc(input int i);
        int n;
        for (n = 0; n < 50 && req_valid[i]; n++) step();
        if (req_valid[i]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: requester %0d got no accept expected one within 50 cycles", i);
        end
    endtask

    task automatic wait_rsp(input string name, input logic [IDW-1:0] id, input logic [31:0] sum,
                            input logic cout, input logic of);
        bit got;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            if (rsp_valid) begin
                chk({name, "_id"},   64'(rsp_id),   64'(id));
                chk({name, "_sum"},  64'(rsp_sum),  64'(sum));
                chk({name, "_cout"}, 64'(rsp_cout), 64'(cout));
                chk({name, "_of"},   64'(rsp_of),   64'(of));
                got = 1;
                break;
            end
            step();
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no rsp_valid expected one within 20 cycles", name);
        end
        step();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom % 6)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    int gid[$];
    int gcyc[$];

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish before 300000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'h0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_rsp_sum",   64'(rsp_sum),   64'h0);
        chk("reset_rsp_id",    64'(rsp_id),    64'h0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // single op and carry/overflow corners
        set_req(0, 32'h0000_0001, 32'h0000_0002, 1'b1);
        wait_acc(0);
        wait_rsp("single", 2'd0, 32'h0000_0004, 1'b0, 1'b0);
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_acc(0);
        wait_rsp("carry", 2'd0, 32'h0000_0000, 1'b1, 1'b0);
        set_req(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_acc(0);
        wait_rsp("ovf", 2'd0, 32'h8000_0000, 1'b0, 1'b1);

        // round-robin with all requesters held valid
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 1'($urandom));
        for (int n = 0; n < 12; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (last_acc[i]) begin
                    gid.push_back(i);
                    gcyc.push_back(stepcnt);
                    set_req(i, $urandom, $urandom, 1'($urandom));
                end
            end
        end
        begin
            int exp_order[5];
            exp_order = '{0, 1, 2, 3, 0};
            if (gid.size() < 5) begin
                total++;
                bad++;
                $display("FAIL rr_count: got %0d grants expected at least 5", gid.size());
            end else begin
                for (int k = 0; k < 5; k++) chk("rr_order", 64'(gid[k]), 64'(exp_order[k]));
                for (int k = 1; k < 5; k++) chk("rr_gap", 64'(gcyc[k] - gcyc[k-1]), 64'd2);
            end
        end
        req_valid = '0;
        repeat (4) step();

        // backpressure: response held for 5 cycles, then back-to-back accept
        set_req(0, 32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_acc(0);
        rsp_ready = 1'b0;
        set_req(1, 32'h0000_0005, 32'h0000_0006, 1'b1);
        for (int n = 0; n < 10 && !rsp_valid; n++) step();
        for (int n = 0; n < 5; n++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_rsp_sum",   64'(rsp_sum),   64'h30);
            chk("bp_rsp_id",    64'(rsp_id),    64'h0);
            chk("bp_req_ready", 64'(req_ready), 64'h0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b0010);
        step();
        wait_rsp("bp_next", 2'd1, 32'h0000_000C, 1'b0, 1'b0);

        // reset while an op is in EXEC
        set_req(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_acc(1);
        set_req(3, 32'h0000_0001, 32'h0000_0001, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_id",    64'(rsp_id),    64'h0);
        chk("rst_rsp_sum",   64'(rsp_sum),   64'h0);
        chk("rst_rsp_cout",  64'(rsp_cout),  64'h0);
        chk("rst_rsp_of",    64'(rsp_of),    64'h0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        set_req(2, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_acc(2);
        wait_rsp("post_rst", 2'd2, 32'h0000_0001, 1'b1, 1'b1);

        // randomized traffic with backpressure and withdrawn requests
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0))
                    set_req(i, rnd_op(), rnd_op(), 1'($urandom));
                else if (req_valid[i] && ($urandom % 16 == 0))
                    req_valid[i] = 1'b0;
            end
            rsp_ready = ($urandom % 4) != 0;
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("drain_queue_empty", 64'(q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
